// File: rtl/shift_add_mult_if.sv
// Request/response bundle for the shift-and-add multiplier.
interface shift_add_mult_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] p;
   logic        busy;
   logic        done;

   modport master (output start, a, b, input  p, busy, done);
   modport slave  (input  start, a, b, output p, busy, done);
endinterface

// File: rtl/shift_add_mult.sv
// 16x16 -> 32 unsigned sequential multiplier: one shift-and-add step per cycle,
// 16 iterations, built around a 16-bit ripple-carry adder.

// Single-bit full adder cell.
module sam_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

// 16-bit ripple-carry adder built from an array of full adder cells.
module sam_rca16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic [16:0] c;

   assign c[0] = ci;
   assign co   = c[16];

   for (genvar i = 0; i < 16; i++) begin : g_bit
      sam_fa u_fa (
         .x  (x[i]),
         .y  (y[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end
endmodule

module shift_add_mult (
   input  logic             clk,
   input  logic             rst,
   shift_add_mult_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] mcand_q, mcand_d;
   // The accumulator is conceptually 33 bits, but its top bit is always zero
   // after the logical right shift, so only the low 32 bits are stored.
   logic [31:0] acc_q, acc_d;
   logic [3:0]  count_q, count_d;
   logic [31:0] p_q, p_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [15:0] sum;
   logic        c1;
   logic [16:0] hi;

   // Upper half plus multiplicand; carry out is kept as bit 16 of the partial sum.
   sam_rca16 u_add (
      .x  (acc_q[31:16]),
      .y  (mcand_q),
      .ci (1'b0),
      .s  (sum),
      .co (c1)
   );

   // Next-state: accept in IDLE, iterate in RUN, single DONE cycle back to IDLE.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      count_d = count_q;
      p_d     = p_q;
      hi      = 17'd0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.a;
               acc_d   = {16'd0, bus.b};
               count_d = 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            hi      = acc_q[0] ? {c1, sum} : {1'b0, acc_q[31:16]};
            acc_d   = {hi, acc_q[15:1]};
            count_d = count_q + 4'd1;
            if (count_q == 4'd15) begin
               state_d = DONE;
               p_d     = acc_d;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and registered outputs; reset aborts any run and clears p.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= 16'd0;
         acc_q   <= 32'd0;
         count_q <= 4'd0;
         p_q     <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.p    = p_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench: directed corner cases plus 1000 random back-to-back
// multiplies, compared against plain a*b arithmetic.
module tb_shift_add_mult;
   logic clk;
   logic rst;
   shift_add_mult_if bus ();

   shift_add_mult dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_p  = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // From a negedge following an accepting edge: step until done, counting
   // edges and busy cycles; p must hold its old value throughout.
   task automatic wait_done(input string tag, output int edges, output int busy_cyc);
      edges    = 0;
      busy_cyc = 0;
      forever begin
         chk({tag, "_busy_done_excl"}, 32'(bus.busy & bus.done), 32'd0);
         if (bus.done) break;
         if (bus.busy) busy_cyc++;
         chk({tag, "_p_hold"}, bus.p, exp_p);
         if (edges >= 40) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   // Called at a negedge; start is sampled on the following rising edge.
   task automatic run_mult(input logic [15:0] ia, input logic [15:0] ib, input string tag);
      int edges, busy_cyc;
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      wait_done(tag, edges, busy_cyc);
      exp_p = 32'(ia) * 32'(ib);
      chk({tag, "_latency"}, 32'(edges), 32'd16);
      chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd16);
      chk({tag, "_p"}, bus.p, exp_p);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int edges, busy_cyc, n_done;
      bus.start = 1'b0;
      bus.a     = 16'd0;
      bus.b     = 16'd0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_p", bus.p, 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      rst = 1'b0;

      // First start accepted on the first edge with rst low.
      run_mult(16'd3, 16'd5, "three_x_five");
      chk("three_x_five_value", bus.p, 32'h0000000F);
      run_mult(16'hFFFF, 16'hFFFF, "max_x_max");
      chk("max_x_max_value", bus.p, 32'hFFFE0001);
      run_mult(16'h1234, 16'h0000, "b_zero");
      run_mult(16'h0000, 16'hABCD, "a_zero");

      // Start held through RUN and DONE with new operands: ignored until IDLE.
      bus.start = 1'b1;
      bus.a     = 16'd2;
      bus.b     = 16'd7;
      @(posedge clk);
      @(negedge clk);
      bus.a  = 16'd9;
      bus.b  = 16'd9;
      n_done = 0;
      for (int i = 1; i <= 17; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) n_done++;
         if (i == 16) chk("held_p", bus.p, 32'h0000000E);
      end
      chk("held_one_done", 32'(n_done), 32'd1);
      chk("held_idle_busy", 32'(bus.busy), 32'd0);
      exp_p = 32'h0000000E;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk("held_accepted", 32'(bus.busy), 32'd1);
      wait_done("held_second", edges, busy_cyc);
      exp_p = 32'h51;
      chk("held_second_latency", 32'(edges), 32'd16);
      chk("held_second_p", bus.p, 32'h00000051);
      @(posedge clk);
      @(negedge clk);

      // Reset in the middle of a run aborts it.
      bus.start = 1'b1;
      bus.a     = 16'h00FF;
      bus.b     = 16'h0100;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      exp_p = 32'd0;
      chk("abort_p", bus.p, 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_p_held", bus.p, 32'd0);
      run_mult(16'h00FF, 16'h0100, "restart");
      chk("restart_value", bus.p, 32'h0000FF00);

      // Reset wins over start on the same edge.
      rst       = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      exp_p     = 32'd0;
      chk("rst_over_start_busy", 32'(bus.busy), 32'd0);
      chk("rst_over_start_p", bus.p, 32'd0);

      // Random operands at the minimum 18-cycle start interval.
      for (int i = 0; i < 1000; i++)
         run_mult(16'($urandom), 16'($urandom), "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
